// File: rtl/system_rule_scheduler.sv
// ---------------------------------------------------------------------------
// system_rule_scheduler
//
// Round-robin rule scheduler for a guarded-rule protocol system. In each RUN
// cycle it enables at most one rule whose guard is true. The search for that
// rule starts at a rotating pointer. The block counts firings against an
// optional step limit, and it declares deadlock when no guard has been true
// for DL_CYC consecutive RUN cycles.
//
// Parameters
//   NUM_RULES  number of rules / width of io_guard and io_en_a (>= 2)
//   STEP_W     width of the firing counter and the step limit
//   DL_CYC     consecutive guard-less RUN cycles that declare deadlock (>= 1)
//
// Ports
//   clock          single clock
//   reset          asynchronous active-high reset
//   io_run         scheduling permitted
//   io_clear       synchronous return to IDLE with counters cleared
//   io_guard       per-rule guard, bit i = rule i may fire this cycle
//   io_step_limit  maximum number of firings (0 = unlimited)
//   io_en_a        one-hot (or zero) rule enable, combinational
//   io_fired_idx   index of the asserted io_en_a bit, else 0
//   io_steps       firings since the last clear or reset
//   io_state       IDLE=0, RUN=1, DONE=2, DEADLOCK=3
//   io_done        high in DONE
//   io_deadlock    high in DEADLOCK
// ---------------------------------------------------------------------------
module system_rule_scheduler #(
   parameter int unsigned NUM_RULES = 5,
   parameter int unsigned STEP_W    = 16,
   parameter int unsigned DL_CYC    = 4,
   localparam int unsigned IDX_W    = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_run,
   input  logic                 io_clear,
   input  logic [NUM_RULES-1:0] io_guard,
   input  logic [STEP_W-1:0]    io_step_limit,
   output logic [NUM_RULES-1:0] io_en_a,
   output logic [IDX_W-1:0]     io_fired_idx,
   output logic [STEP_W-1:0]    io_steps,
   output logic [1:0]           io_state,
   output logic                 io_done,
   output logic                 io_deadlock
);

   localparam int unsigned IW = $clog2(DL_CYC + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      DONE     = 2'd2,
      DEADLOCK = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  ptr, ptr_nxt;
   logic [STEP_W-1:0] steps, steps_nxt;
   logic [IW-1:0]     idle_cnt, idle_nxt;

   logic              limit_set;
   logic              below_limit;
   logic              last_step;
   logic              grant_ok;
   logic              found;
   logic              grant;
   logic [IDX_W-1:0]  gidx;
   logic [IDX_W:0]    sum;
   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  ptr_inc;
   logic [STEP_W-1:0] steps_inc;

   // ------------------------------------------------------------------
   // Grant qualification
   // ------------------------------------------------------------------
   assign limit_set   = (io_step_limit != '0);
   assign below_limit = (steps < io_step_limit);
   // The extra bit keeps steps+1 from wrapping to zero when it is compared
   // against the limit.
   assign last_step   = limit_set &&
                        (({1'b0, steps} + 1'b1) == {1'b0, io_step_limit});
   assign grant_ok    = (state == RUN) && io_run && !io_clear &&
                        (!limit_set || below_limit);

   // ------------------------------------------------------------------
   // Round-robin search: offset k from ptr, wrapped modulo NUM_RULES.
   // The first guard bit found wins.
   // ------------------------------------------------------------------
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      sum   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_RULES; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_RULES))
            sum = sum - (IDX_W+1)'(NUM_RULES);
         cand = sum[IDX_W-1:0];
         if (!found && io_guard[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
   end

   assign grant = grant_ok && found;

   always_comb begin
      io_en_a = '0;
      if (grant)
         io_en_a[gidx] = 1'b1;
   end

   assign io_fired_idx = grant ? gidx : '0;

   assign ptr_inc   = (gidx == IDX_W'(NUM_RULES - 1)) ? '0 : gidx + 1'b1;
   // Steps saturate instead of wrapping. This only matters when no limit
   // is set, because a limit stops the count first.
   assign steps_inc = (steps == '1) ? steps : steps + 1'b1;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         steps    <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         steps    <= steps_nxt;
         idle_cnt <= idle_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      steps_nxt = steps;
      idle_nxt  = idle_cnt;
      if (io_clear) begin
         state_nxt = IDLE;
         ptr_nxt   = '0;
         steps_nxt = '0;
         idle_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (io_run)
                  state_nxt = RUN;
            end
            RUN: begin
               if (!io_run) begin
                  state_nxt = IDLE;
               end else if (limit_set && !below_limit) begin
                  // The limit was lowered below the count while running.
                  state_nxt = DONE;
               end else if (grant) begin
                  ptr_nxt   = ptr_inc;
                  steps_nxt = steps_inc;
                  idle_nxt  = '0;
                  if (last_step)
                     state_nxt = DONE;
               end else begin
                  // Only reachable with io_guard == 0. The limit checks
                  // above run first, so reaching DONE beats deadlock.
                  idle_nxt = idle_cnt + IW'(1);
                  if (idle_cnt == IW'(DL_CYC - 1))
                     state_nxt = DEADLOCK;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Status outputs
   // ------------------------------------------------------------------
   assign io_steps    = steps;
   assign io_state    = state;
   assign io_done     = (state == DONE);
   assign io_deadlock = (state == DEADLOCK);

endmodule

// File: tb/tb_system_rule_scheduler.sv
// ---------------------------------------------------------------------------
// tb_system_rule_scheduler
//
// Directed testbench for system_rule_scheduler with the default parameters.
// Each stimulus step drives the inputs just after a rising edge and queues
// the outputs expected for that cycle. A monitor samples the outputs on the
// falling edge and compares them against the head of the queue. On every
// falling edge it also checks that io_en_a is zero or one-hot and that it
// only enables rules whose guard is true.
// ---------------------------------------------------------------------------
module tb_system_rule_scheduler;

   localparam int unsigned NR = 5;
   localparam int unsigned SW = 16;

   logic          clock;
   logic          reset;
   logic          io_run;
   logic          io_clear;
   logic [NR-1:0] io_guard;
   logic [SW-1:0] io_step_limit;
   logic [NR-1:0] io_en_a;
   logic [2:0]    io_fired_idx;
   logic [SW-1:0] io_steps;
   logic [1:0]    io_state;
   logic          io_done;
   logic          io_deadlock;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string         name;
      logic [NR-1:0] en;
      logic [2:0]    idx;
      logic [SW-1:0] steps;
      logic [1:0]    st;
   } exp_t;

   exp_t exp_q[$];

   system_rule_scheduler #(
      .NUM_RULES (NR),
      .STEP_W    (SW),
      .DL_CYC    (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .io_run        (io_run),
      .io_clear      (io_clear),
      .io_guard      (io_guard),
      .io_step_limit (io_step_limit),
      .io_en_a       (io_en_a),
      .io_fired_idx  (io_fired_idx),
      .io_steps      (io_steps),
      .io_state      (io_state),
      .io_done       (io_done),
      .io_deadlock   (io_deadlock)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: per-cycle invariants, then the scoreboard entry for this cycle.
   initial begin
      exp_t e;
      logic [NR-1:0] onehot_chk;
      forever begin
         @(negedge clock);
         onehot_chk = io_en_a & (io_en_a - 1'b1);
         chk("en_onehot", 32'(onehot_chk), 32'd0);
         chk("en_guarded", 32'(io_en_a & ~io_guard), 32'd0);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".en_a"},     32'(io_en_a),      32'(e.en));
            chk({e.name, ".idx"},      32'(io_fired_idx), 32'(e.idx));
            chk({e.name, ".steps"},    32'(io_steps),     32'(e.steps));
            chk({e.name, ".state"},    32'(io_state),     32'(e.st));
            chk({e.name, ".done"},     32'(io_done),      32'(e.st == 2'd2));
            chk({e.name, ".deadlock"}, 32'(io_deadlock),  32'(e.st == 2'd3));
         end
      end
   end

   // One cycle of stimulus. When rmid is set, reset is applied partway
   // through the cycle instead of together with the other inputs.
   task automatic step(input logic rst, input logic rmid,
                       input logic run, input logic clr,
                       input logic [NR-1:0] guard, input logic [SW-1:0] limit,
                       input logic [NR-1:0] en, input logic [2:0] idx,
                       input logic [SW-1:0] stp, input logic [1:0] st,
                       input string name);
      exp_t e;
      @(posedge clock);
      #1;
      io_run        = run;
      io_clear      = clr;
      io_guard      = guard;
      io_step_limit = limit;
      if (!rmid) reset = rst;
      e.name = name; e.en = en; e.idx = idx; e.steps = stp; e.st = st;
      exp_q.push_back(e);
      if (rmid) begin
         #2;
         reset = rst;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; io_run = 1'b0; io_clear = 1'b0;
      io_guard = '0; io_step_limit = '0;

      // reset
      step(1,0, 0,0,5'b00000,0, 5'b00000,0,0,0, "rst_hold");
      step(1,0, 1,0,5'b11111,0, 5'b00000,0,0,0, "rst_hold_run");
      step(0,0, 0,0,5'b11111,0, 5'b00000,0,0,0, "idle_after_rst");
      // round robin
      step(0,0, 1,0,5'b10110,0, 5'b00000,0,0,0, "rr_idle");
      step(0,0, 1,0,5'b10110,0, 5'b00010,1,0,1, "rr_g1");
      step(0,0, 1,0,5'b10110,0, 5'b00100,2,1,1, "rr_g2");
      step(0,0, 1,0,5'b10110,0, 5'b10000,4,2,1, "rr_g3");
      step(0,0, 1,0,5'b10110,0, 5'b00010,1,3,1, "rr_g4");
      step(0,0, 1,1,5'b10110,0, 5'b00000,0,4,1, "rr_clear");
      // step limit
      step(0,0, 1,0,5'b00001,3, 5'b00000,0,0,0, "lim_idle");
      step(0,0, 1,0,5'b00001,3, 5'b00001,0,0,1, "lim_g1");
      step(0,0, 1,0,5'b00001,3, 5'b00001,0,1,1, "lim_g2");
      step(0,0, 1,0,5'b00001,3, 5'b00001,0,2,1, "lim_g3");
      step(0,0, 1,0,5'b00001,3, 5'b00000,0,3,2, "lim_done");
      step(0,0, 0,0,5'b11111,3, 5'b00000,0,3,2, "lim_hold");
      step(0,0, 0,1,5'b11111,3, 5'b00000,0,3,2, "lim_clear");
      // deadlock
      step(0,0, 1,0,5'b00000,0, 5'b00000,0,0,0, "dl_idle");
      step(0,0, 1,0,5'b00000,0, 5'b00000,0,0,1, "dl_run1");
      step(0,0, 1,0,5'b00000,0, 5'b00000,0,0,1, "dl_run2");
      step(0,0, 1,0,5'b00000,0, 5'b00000,0,0,1, "dl_run3");
      step(0,0, 1,0,5'b00000,0, 5'b00000,0,0,1, "dl_run4");
      step(0,0, 1,0,5'b11111,0, 5'b00000,0,0,3, "dl_hold1");
      step(0,0, 1,0,5'b11111,0, 5'b00000,0,0,3, "dl_hold2");
      step(0,0, 1,1,5'b11111,0, 5'b00000,0,0,3, "dl_clear");
      step(0,0, 0,0,5'b00000,0, 5'b00000,0,0,0, "dl_idle_after");
      // run pause
      step(0,0, 1,0,5'b11111,0, 5'b00000,0,0,0, "pz_idle");
      step(0,0, 1,0,5'b11111,0, 5'b00001,0,0,1, "pz_g1");
      step(0,0, 1,0,5'b11111,0, 5'b00010,1,1,1, "pz_g2");
      step(0,0, 0,0,5'b11111,0, 5'b00000,0,2,1, "pz_drop");
      step(0,0, 0,0,5'b11111,0, 5'b00000,0,2,0, "pz_idle2");
      step(0,0, 1,0,5'b11111,0, 5'b00000,0,2,0, "pz_rearm");
      step(0,0, 1,0,5'b11111,0, 5'b00100,2,2,1, "pz_g3");
      // clear versus run
      step(0,0, 1,1,5'b01010,0, 5'b00000,0,3,1, "cr_clear");
      step(0,0, 1,0,5'b01010,0, 5'b00000,0,0,0, "cr_idle");
      step(0,0, 1,0,5'b01010,0, 5'b00010,1,0,1, "cr_g1");
      // limit lowered below the count mid-run
      step(0,0, 1,0,5'b01010,1, 5'b00000,0,1,1, "ll_reached");
      step(0,0, 1,0,5'b01010,1, 5'b00000,0,1,2, "ll_done");
      step(0,0, 0,1,5'b00000,0, 5'b00000,0,1,2, "ll_clear");
      // asynchronous reset mid-RUN
      step(0,0, 1,0,5'b11111,0, 5'b00000,0,0,0, "ar_idle");
      step(0,0, 1,0,5'b11111,0, 5'b00001,0,0,1, "ar_g1");
      step(1,1, 1,0,5'b11111,0, 5'b00000,0,0,0, "ar_mid");
      step(1,0, 1,0,5'b11111,0, 5'b00000,0,0,0, "ar_hold");
      step(0,0, 1,0,5'b11111,0, 5'b00000,0,0,0, "ar_resume_idle");
      step(0,0, 1,0,5'b11111,0, 5'b00001,0,0,1, "ar_g1b");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/system_rule_scheduler.md
SYSTEM_RULE_SCHEDULER -- requirements
Module: system_rule_scheduler

Interface
REQ-001 SHALL have parameter NUM_RULES, default 5, the number of rule enables driven into the protocol system.
REQ-002 SHALL have parameter STEP_W, default 16, the step counter width.
REQ-003 SHALL have parameter DL_CYC, default 4, the number of consecutive guard-less RUN cycles that declares deadlock.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clock, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port io_run, input, 1 bit: scheduling permitted.
REQ-008 SHALL have port io_clear, input, 1 bit: synchronous return to IDLE with counters cleared.
REQ-009 SHALL have port io_guard, input, NUM_RULES bits: bit i means rule i's guard is true this cycle.
REQ-010 SHALL have port io_step_limit, input, STEP_W bits: maximum firings, where 0 means unlimited.
REQ-011 SHALL have port io_en_a, output, NUM_RULES bits: one-hot rule enable to the system.
REQ-012 SHALL have port io_fired_idx, output, clog2(NUM_RULES) bits: index of the asserted io_en_a bit, else 0.
REQ-013 SHALL have port io_steps, output, STEP_W bits: firings since the last clear or reset.
REQ-014 SHALL have port io_state, output, 2 bits: IDLE=0, RUN=1, DONE=2, DEADLOCK=3.
REQ-015 SHALL have ports io_done and io_deadlock, outputs, 1 bit each: high exactly when io_state is DONE or DEADLOCK respectively.

Function
REQ-016 SHALL hold registered state: FSM state, round-robin pointer ptr (0..NUM_RULES-1), steps (STEP_W bits) and idle counter idle_cnt.
REQ-017 SHALL define grant_ok = (state==RUN) & io_run & ~io_clear & (io_step_limit==0 | steps<io_step_limit).
REQ-018 SHALL drive io_en_a combinationally: when grant_ok and io_guard!=0, the single bit of the first set io_guard bit searched from ptr upward, wrapping modulo NUM_RULES; otherwise all zeros.
REQ-019 SHALL guarantee io_en_a is zero or one-hot in every cycle, and never asserts a bit whose io_guard bit is 0.
REQ-020 SHALL, on each grant of rule g, set ptr to (g+1) mod NUM_RULES, increment steps, and clear idle_cnt at that edge.
REQ-021 SHALL leave ptr unchanged on cycles without a grant.
REQ-022 SHALL saturate steps at all-ones when io_step_limit==0, with no wrap.
REQ-023 SHALL transition IDLE->RUN at the edge where io_run=1 and io_clear=0, with no grant in the IDLE cycle.
REQ-024 SHALL transition RUN->IDLE when io_run=0, retaining ptr, steps and idle_cnt.
REQ-025 SHALL transition RUN->DONE at the grant edge where io_step_limit!=0 and steps+1==io_step_limit.
REQ-026 SHALL also transition RUN->DONE, with no grant, when io_step_limit!=0 and steps>=io_step_limit (limit lowered mid-run).
REQ-027 SHALL increment idle_cnt in RUN with io_run=1 and io_guard==0, and transition RUN->DEADLOCK at the edge where idle_cnt reaches DL_CYC.
REQ-028 SHALL hold DONE and DEADLOCK with io_en_a=0 regardless of io_guard or io_run.
REQ-029 SHALL, when io_clear=1 in any state, go to IDLE and zero ptr, steps and idle_cnt; io_clear overrides io_run and grants, so a concurrent io_run reaches RUN one edge later.
REQ-030 SHALL give a limit reach (DONE) priority over deadlock when both occur at the same edge.

Reset
REQ-031 SHALL, while reset=1, immediately force state IDLE, ptr=0, steps=0 and idle_cnt=0, independent of clock.
REQ-032 SHALL hold all outputs at zero during reset, including io_state=0.
REQ-033 SHALL resume in IDLE after reset deasserts, requiring io_run before the first grant.
REQ-034 SHALL, on reset asserted mid-RUN, drop io_en_a to zero combinationally in the same cycle.

Verification
REQ-035 SHALL cover round robin: io_run=1, io_guard=10110, io_step_limit=0 -> io_en_a sequence 00010, 00100, 10000, 00010, with io_steps counting 1, 2, 3, 4.
REQ-036 SHALL cover step limit: io_step_limit=3, io_guard=00001 -> three grants, then io_state=DONE, io_steps=3, io_en_a=0 thereafter.
REQ-037 SHALL cover deadlock: io_guard=00000 for 4 RUN cycles -> io_deadlock=1; a following io_guard=11111 gives no grant; io_clear=1 -> IDLE with io_steps=0.
REQ-038 SHALL cover run pause: io_run dropped after 2 grants with io_guard=11111 -> IDLE, io_steps=2; io_run reasserted -> next grant is 00100.
REQ-039 SHALL cover clear versus run: io_clear=1 with io_run=1 in RUN -> IDLE, ptr=0; RUN one edge later; first grant is the lowest set guard bit.
REQ-040 SHALL cover asynchronous reset mid-RUN: io_en_a goes to 0 and io_state to 0 before the next clock edge.
